axi_spy_monitor: RTL and testbench

// - Passive monitor on one AXI3 master/slave link. Captures AR, AW, W and R handshakes into four per-channel

---
 rtl/axi_spy_pkg.sv | 13 +
 rtl/spy_trace_fifo.sv | 45 ++++
 rtl/axi_spy_monitor.sv | 163 ++++++++++++++++
 tb/tb_axi_spy_monitor.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_spy_pkg.sv
// Shared types and helpers for the AXI spy monitor.
// Channel encoding, channel count and a width helper.
package axi_spy_pkg;

  typedef enum logic [1:0] {CH_AR, CH_AW, CH_W, CH_R} chan_e;

  localparam int NUM_CH = 4;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spy_trace_fifo.sv
// Per-channel trace FIFO. The head is read combinationally.
// An overwrite pushes and advances the read pointer in the same cycle.
module spy_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             force_drop_oldest,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)                     wptr <= wptr + PW'(1);
      if (pop || force_drop_oldest) rptr <= rptr + PW'(1);
    end
  end

  // When full, the write slot is the head slot, so a push only lands after
  // that head has been popped or deliberately discarded.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_spy_monitor.sv
// Passive AXI3 monitor that captures AR/AW/W/R handshakes into trace FIFOs.
// The FIFOs drain through a round-robin valid/ready readout port.
module axi_spy_monitor
  import axi_spy_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int OVERWRITE  = 1,
  parameter int FILTER_ID  = 1,
  localparam int PAY_W     = max(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [ID_WIDTH-1:0]       ARID,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      AWVALID,
  input  logic                      AWREADY,
  input  logic [ID_WIDTH-1:0]       AWID,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      WVALID,
  input  logic                      WREADY,
  input  logic [ID_WIDTH-1:0]       WID,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic                      RVALID,
  input  logic                      RREADY,
  input  logic [ID_WIDTH-1:0]       RID,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [3:0]                cap_en,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_chan,
  output logic [TS_WIDTH-1:0]       out_ts,
  output logic [ID_WIDTH-1:0]       out_id,
  output logic [PAY_W-1:0]          out_payload,
  output logic [3:0]                spy_full,
  output logic [4*CNT_WIDTH-1:0]    drop_cnt
);

  localparam int REC_W = TS_WIDTH + ID_WIDTH + PAY_W;

  logic                 clr;
  logic [TS_WIDTH-1:0]  ts;
  logic [NUM_CH-1:0]    hs, cand, push, drop_old, pop, stall_c, drop_ev;
  logic [NUM_CH-1:0]    empty, full, last_vld;
  logic [ID_WIDTH-1:0]  cap_id   [NUM_CH];
  logic [PAY_W-1:0]     cap_pay  [NUM_CH];
  logic [ID_WIDTH-1:0]  last_id  [NUM_CH];
  logic [REC_W-1:0]     head     [NUM_CH];
  logic [CNT_WIDTH-1:0] drop_q   [NUM_CH];
  logic [1:0]           rr_ptr, grant;
  logic                 any_ne;

  assign clr = reset | flush;

  // Handshake capture: per-channel ID and zero-extended payload
  always_comb begin
    hs = {RVALID & RREADY, WVALID & WREADY, AWVALID & AWREADY, ARVALID & ARREADY};
    cap_id[0] = ARID;
    cap_id[1] = AWID;
    cap_id[2] = WID;
    cap_id[3] = RID;
    for (int c = 0; c < NUM_CH; c++) cap_pay[c] = '0;
    cap_pay[0][ADDR_WIDTH-1:0] = ARADDR;
    cap_pay[1][ADDR_WIDTH-1:0] = AWADDR;
    cap_pay[2][DATA_WIDTH-1:0] = WDATA;
    cap_pay[3][DATA_WIDTH-1:0] = RDATA;
  end

  // Filter and full policy; a presented-but-stalled head is never overwritten
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cand[c]     = hs[c] & cap_en[c] &
                    ((FILTER_ID == 0) | ~last_vld[c] | (cap_id[c] != last_id[c]));
      pop[c]      = out_valid & out_ready & (grant == 2'(c));
      stall_c[c]  = out_valid & ~out_ready & (grant == 2'(c));
      push[c]     = 1'b0;
      drop_old[c] = 1'b0;
      drop_ev[c]  = 1'b0;
      if (cand[c]) begin
        if (!full[c] || pop[c]) begin
          push[c] = 1'b1;
        end else if ((OVERWRITE != 0) && !stall_c[c]) begin
          push[c]     = 1'b1;
          drop_old[c] = 1'b1;
          drop_ev[c]  = 1'b1;
        end else begin
          drop_ev[c] = 1'b1;
        end
      end
    end
  end

  // Round-robin grant: first non-empty channel at or after rr_ptr
  always_comb begin
    grant  = rr_ptr;
    any_ne = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!any_ne && !empty[rr_ptr + 2'(k)]) begin
        grant  = rr_ptr + 2'(k);
        any_ne = 1'b1;
      end
    end
  end

  assign out_valid = any_ne;
  assign out_chan  = grant;
  assign {out_ts, out_id, out_payload} = head[grant];
  assign spy_full  = full;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_WIDTH'(1);
  end

  // A stall parks rr_ptr on the granted channel so the grant cannot move
  // when an earlier channel fills in behind it.
  always_ff @(posedge clk) begin
    if (clr) begin
      rr_ptr   <= CH_AR;
      last_vld <= '0;
      for (int c = 0; c < NUM_CH; c++) drop_q[c] <= '0;
    end else begin
      if (out_valid && out_ready) rr_ptr <= grant + 2'd1;
      else if (out_valid)         rr_ptr <= grant;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cand[c]) last_vld[c] <= 1'b1;
        if (drop_ev[c] && (drop_q[c] != '1)) drop_q[c] <= drop_q[c] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (cand[c]) last_id[c] <= cap_id[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    spy_trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk               (clk),
      .rst               (clr),
      .push              (push[c]),
      .push_data         ({ts, cap_id[c], cap_pay[c]}),
      .pop               (pop[c]),
      .force_drop_oldest (drop_old[c]),
      .head_data         (head[c]),
      .full              (full[c]),
      .empty             (empty[c])
    );
    assign drop_cnt[c*CNT_WIDTH +: CNT_WIDTH] = drop_q[c];
  end

endmodule

// File: tb/tb_axi_spy_monitor.sv
// Bench for axi_spy_monitor: two instances (overwrite+filter, keep-old+no-filter)
// share stimulus and are checked every cycle against a queue-based model.
module tb_axi_spy_monitor;

  logic clk = 1'b0;
  logic reset, flush, out_ready;
  logic arvalid, arready, awvalid, awready, wvalid, wready, rvalid, rready;
  logic [3:0]  arid, awid, wid, rid, cap_en;
  logic [31:0] araddr, awaddr, wdata, rdata;

  logic        ov    [2];
  logic [1:0]  oc    [2];
  logic [15:0] ots   [2];
  logic [3:0]  oid   [2];
  logic [31:0] opay  [2];
  logic [3:0]  sfull [2];
  logic [31:0] dc    [2];

  always #5 clk = ~clk;

  axi_spy_monitor #(.OVERWRITE(1), .FILTER_ID(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .ARVALID(arvalid), .ARREADY(arready), .ARID(arid), .ARADDR(araddr),
    .AWVALID(awvalid), .AWREADY(awready), .AWID(awid), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(wready), .WID(wid), .WDATA(wdata),
    .RVALID(rvalid), .RREADY(rready), .RID(rid), .RDATA(rdata),
    .cap_en(cap_en), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_chan(oc[0]), .out_ts(ots[0]),
    .out_id(oid[0]), .out_payload(opay[0]), .spy_full(sfull[0]), .drop_cnt(dc[0])
  );

  axi_spy_monitor #(.OVERWRITE(0), .FILTER_ID(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .ARVALID(arvalid), .ARREADY(arready), .ARID(arid), .ARADDR(araddr),
    .AWVALID(awvalid), .AWREADY(awready), .AWID(awid), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(wready), .WID(wid), .WDATA(wdata),
    .RVALID(rvalid), .RREADY(rready), .RID(rid), .RDATA(rdata),
    .cap_en(cap_en), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_chan(oc[1]), .out_ts(ots[1]),
    .out_id(oid[1]), .out_payload(opay[1]), .spy_full(sfull[1]), .drop_cnt(dc[1])
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instance 0 overwrites and filters, instance 1 keeps old and captures all
  typedef struct packed {
    logic [15:0] ts;
    logic [3:0]  id;
    logic [31:0] pay;
  } rec_t;

  rec_t        q      [2][4][$];
  int          rr_m   [2];
  bit          held_m [2];
  int          hg_m   [2];
  bit          lv_m   [2][4];
  logic [3:0]  li_m   [2][4];
  int          drop_m [2][4];
  logic [15:0] ts_m = '0;

  function automatic int exp_grant(input int m);
    if (held_m[m]) return hg_m[m];
    for (int k = 0; k < 4; k++) begin
      if (q[m][(rr_m[m] + k) % 4].size() > 0) return (rr_m[m] + k) % 4;
    end
    return -1;
  endfunction

  task automatic sample();
    int g;
    rec_t r;
    logic [3:0] ef;
    logic [31:0] ed;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      g = exp_grant(m);
      chk($sformatf("m%0d_valid", m), ov[m], g >= 0);
      if (g >= 0) begin
        r = q[m][g][0];
        chk($sformatf("m%0d_chan", m), oc[m], g);
        chk($sformatf("m%0d_ts", m), ots[m], r.ts);
        chk($sformatf("m%0d_id", m), oid[m], r.id);
        chk($sformatf("m%0d_pay", m), opay[m], r.pay);
      end
      for (int c = 0; c < 4; c++) begin
        ef[c] = (q[m][c].size() == 16);
        ed[c*8 +: 8] = 8'(drop_m[m][c]);
      end
      chk($sformatf("m%0d_full", m), sfull[m], ef);
      chk($sformatf("m%0d_drop", m), dc[m], ed);
    end
  endtask

  task automatic advance();
    logic [3:0]  hs;
    logic [3:0]  idv [4];
    logic [31:0] pv  [4];
    int g;
    bit popg, stl;
    rec_t r;
    hs     = {rvalid & rready, wvalid & wready, awvalid & awready, arvalid & arready};
    idv[0] = arid;   idv[1] = awid;   idv[2] = wid;   idv[3] = rid;
    pv[0]  = araddr; pv[1]  = awaddr; pv[2]  = wdata; pv[3]  = rdata;
    for (int m = 0; m < 2; m++) begin
      if (reset || flush) begin
        for (int c = 0; c < 4; c++) begin
          q[m][c].delete();
          lv_m[m][c]   = 1'b0;
          drop_m[m][c] = 0;
        end
        rr_m[m]   = 0;
        held_m[m] = 1'b0;
      end else begin
        g    = exp_grant(m);
        popg = (g >= 0) && out_ready;
        stl  = (g >= 0) && !out_ready;
        if (popg) void'(q[m][g].pop_front());
        for (int c = 0; c < 4; c++) begin
          if (hs[c] && cap_en[c] && (m == 1 || !lv_m[m][c] || idv[c] != li_m[m][c])) begin
            lv_m[m][c] = 1'b1;
            li_m[m][c] = idv[c];
            r.ts  = ts_m;
            r.id  = idv[c];
            r.pay = pv[c];
            if (q[m][c].size() < 16) begin
              q[m][c].push_back(r);
            end else begin
              if (m == 0 && !(stl && g == c)) begin
                void'(q[m][c].pop_front());
                q[m][c].push_back(r);
              end
              if (drop_m[m][c] < 255) drop_m[m][c]++;
            end
          end
        end
        if (popg) rr_m[m] = (g + 1) % 4;
        held_m[m] = stl;
        hg_m[m]   = g;
      end
    end
    ts_m = reset ? 16'd0 : ts_m + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic idle();
    arvalid = 0; awvalid = 0; wvalid = 0; rvalid = 0;
    arready = 1; awready = 1; wready = 1; rready = 1;
  endtask

  int          cnt [2];
  logic [31:0] first_p [2];
  logic [31:0] last_p  [2];
  logic [7:0]  seqv    [2];
  int          npop    [2];
  logic [15:0] tf;

  initial begin
    reset = 1; flush = 0; out_ready = 1; cap_en = 4'hF;
    arid = 0; awid = 0; wid = 0; rid = 0;
    araddr = 0; awaddr = 0; wdata = 0; rdata = 0;
    idle();
    repeat (3) step();
    reset = 0;
    sample();
    chk("rst_valid", ov[0], 1'b0);
    chk("rst_full", sfull[1], 4'h0);
    chk("rst_drop", dc[1], 32'h0);
    advance();

    // single AR beat at ts=5
    while (ts_m != 16'd5) step();
    arvalid = 1; arid = 4'd3; araddr = 32'h1000;
    step();
    idle();
    sample();
    chk("sb_valid", ov[0], 1'b1);
    chk("sb_chan", oc[0], 2'd0);
    chk("sb_id", oid[0], 4'd3);
    chk("sb_pay", opay[0], 32'h1000);
    chk("sb_ts", ots[0], 16'd5);
    advance();

    // ID filter: RID 2,2,2,7
    out_ready = 0;
    foreach (cnt[m]) cnt[m] = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rid = (i == 3) ? 4'd7 : 4'd2; rdata = 32'h300 + i;
      step();
    end
    idle();
    out_ready = 1;
    repeat (6) begin
      sample();
      for (int m = 0; m < 2; m++) if (ov[m] && oc[m] == 2'd3) cnt[m]++;
      advance();
    end
    chk("filt_on_cnt", cnt[0], 2);
    chk("filt_off_cnt", cnt[1], 4);

    // AW full with readout stalled on an AR record
    out_ready = 0;
    arvalid = 1; arid = 4'd5; araddr = 32'hA0;
    step();
    idle();
    for (int i = 0; i < 17; i++) begin
      awvalid = 1; awid = 4'(i % 16); awaddr = 32'h2000 + i;
      step();
    end
    idle();
    sample();
    chk("full_aw0", sfull[0][1], 1'b1);
    chk("full_aw1", sfull[1][1], 1'b1);
    chk("drop_aw0", dc[0][15:8], 8'd1);
    chk("drop_aw1", dc[1][15:8], 8'd1);
    advance();
    out_ready = 1;
    foreach (cnt[m]) begin cnt[m] = 0; first_p[m] = '0; last_p[m] = '0; end
    repeat (20) begin
      sample();
      for (int m = 0; m < 2; m++) begin
        if (ov[m] && oc[m] == 2'd1) begin
          if (cnt[m] == 0) first_p[m] = opay[m];
          last_p[m] = opay[m];
          cnt[m]++;
        end
      end
      advance();
    end
    chk("ovr_first", first_p[0], 32'h2001);
    chk("ovr_last", last_p[0], 32'h2010);
    chk("ovr_cnt", cnt[0], 16);
    chk("keep_first", first_p[1], 32'h2000);
    chk("keep_last", last_p[1], 32'h200F);
    chk("keep_cnt", cnt[1], 16);

    // flush with 5 queued records
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      arvalid = 1; arid = 4'(8 + i); araddr = 32'h400 + i;
      step();
    end
    idle();
    flush = 1;
    tf = ts_m;
    step();
    flush = 0;
    sample();
    chk("fl_valid0", ov[0], 1'b0);
    chk("fl_valid1", ov[1], 1'b0);
    chk("fl_drop0", dc[0], 32'h0);
    chk("fl_drop1", dc[1], 32'h0);
    advance();
    arvalid = 1; arid = 4'd1; araddr = 32'h500;
    step();
    idle();
    sample();
    chk("fl_ts", ots[0], tf + 16'd2);
    advance();
    out_ready = 1;
    repeat (3) step();

    // reset with 5 queued records
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      awvalid = 1; awid = 4'(i); awaddr = 32'h600 + i;
      step();
    end
    idle();
    reset = 1;
    step();
    reset = 0;
    arvalid = 1; arid = 4'd9; araddr = 32'h700;
    sample();
    chk("rs_valid", ov[0], 1'b0);
    advance();
    idle();
    sample();
    chk("rs_cap_valid", ov[1], 1'b1);
    chk("rs_ts", ots[0], 16'd0);
    advance();
    out_ready = 1;
    repeat (3) step();

    // arbitration: one record per channel, then continuous and toggled readout
    for (int pass = 0; pass < 2; pass++) begin
      flush = 1;
      step();
      flush = 0;
      out_ready = 0;
      arvalid = 1; awvalid = 1; wvalid = 1; rvalid = 1;
      arid = 1; awid = 2; wid = 3; rid = 4;
      araddr = 32'h10; awaddr = 32'h20; wdata = 32'h30; rdata = 32'h40;
      step();
      idle();
      foreach (seqv[m]) begin seqv[m] = '0; npop[m] = 0; end
      for (int i = 0; i < 10; i++) begin
        out_ready = (pass == 0) ? 1'b1 : 1'(i % 2);
        sample();
        for (int m = 0; m < 2; m++) begin
          if (ov[m] && out_ready && npop[m] < 4) begin
            seqv[m] = {seqv[m][5:0], oc[m]};
            npop[m]++;
          end
        end
        advance();
      end
      chk($sformatf("arb_seq0_p%0d", pass), seqv[0], 8'h1B);
      chk($sformatf("arb_seq1_p%0d", pass), seqv[1], 8'h1B);
    end

    // drop counter saturation
    out_ready = 0;
    for (int i = 0; i < 300; i++) begin
      awvalid = 1; awid = 4'(i % 2); awaddr = 32'h800 + i;
      step();
    end
    idle();
    sample();
    chk("sat_aw0", dc[0][15:8], 8'hFF);
    chk("sat_aw1", dc[1][15:8], 8'hFF);
    advance();
    flush = 1;
    step();
    flush = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arvalid = 1'($urandom_range(0, 1)); arready = ($urandom_range(0, 3) != 0);
      awvalid = 1'($urandom_range(0, 1)); awready = ($urandom_range(0, 3) != 0);
      wvalid  = 1'($urandom_range(0, 1)); wready  = ($urandom_range(0, 3) != 0);
      rvalid  = 1'($urandom_range(0, 1)); rready  = ($urandom_range(0, 3) != 0);
      arid = 4'($urandom_range(0, 3)); awid = 4'($urandom_range(0, 3));
      wid  = 4'($urandom_range(0, 3)); rid  = 4'($urandom_range(0, 3));
      araddr = $urandom; awaddr = $urandom; wdata = $urandom; rdata = $urandom;
      cap_en = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 499) == 0);
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 0; flush = 0;
    idle();
    out_ready = 1;
    repeat (80) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
